// File: rtl/cascade_sos_iir_tdm.sv
// Multi-channel cascade of transposed-DF-II biquads sharing one multiplier.
// Each accepted sample runs SOS_NUM sections at five products per section.
module cascade_sos_iir_tdm #(
    parameter int unsigned WD       = 16,
    parameter int unsigned IIR_WD   = 24,
    parameter int unsigned COF_WD   = 18,
    parameter int unsigned COF_FRAC = 14,
    parameter int unsigned SOS_NUM  = 4,
    parameter int unsigned CH_NUM   = 2,
    localparam int unsigned CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        clear_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [CH_W-1:0]             in_chan_i,
    input  logic [WD-1:0]               in_data_i,
    input  logic [SOS_NUM*5*COF_WD-1:0] coeff_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CH_W-1:0]             out_chan_o,
    output logic [WD-1:0]               out_data_o,
    output logic                        busy_o
);
    localparam int unsigned SEC_W = (SOS_NUM > 1) ? $clog2(SOS_NUM) : 1;
    localparam int unsigned PW    = IIR_WD + COF_WD;
    localparam int unsigned AW    = IIR_WD + COF_WD + 2;

    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-IIR_WD+1){1'b0}}, {(IIR_WD-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-IIR_WD+1){1'b1}}, {(IIR_WD-1){1'b0}}};
    localparam logic signed [IIR_WD-1:0] OUT_MAX = {{(IIR_WD-WD+1){1'b0}}, {(WD-1){1'b1}}};
    localparam logic signed [IIR_WD-1:0] OUT_MIN = {{(IIR_WD-WD+1){1'b1}}, {(WD-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                   state, state_nxt;
    logic [2:0]               step;
    logic [SEC_W-1:0]         sec;
    logic [CH_W-1:0]          chan;
    logic signed [IIR_WD-1:0] x, y;
    logic signed [AW-1:0]     acc;
    logic signed [IIR_WD-1:0] s1 [CH_NUM][SOS_NUM];
    logic signed [IIR_WD-1:0] s2 [CH_NUM][SOS_NUM];

    logic                     accept, do_clear, last_step;
    logic [2:0]               cidx;
    int                       cbase;
    logic signed [COF_WD-1:0] coef;
    logic signed [IIR_WD-1:0] opnd;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     addend, acc_nxt;
    logic                     sub;
    logic signed [IIR_WD-1:0] sat_q;

    // Rescale the accumulator to state precision, clamping to the IIR_WD range.
    function automatic logic signed [IIR_WD-1:0] sat_acc(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] sh;
        sh = a >>> COF_FRAC;
        if (sh > ACC_MAX)      return ACC_MAX[IIR_WD-1:0];
        else if (sh < ACC_MIN) return ACC_MIN[IIR_WD-1:0];
        else                   return sh[IIR_WD-1:0];
    endfunction

    function automatic logic [WD-1:0] sat_out(input logic signed [IIR_WD-1:0] v);
        if (v > OUT_MAX)      return OUT_MAX[WD-1:0];
        else if (v < OUT_MIN) return OUT_MIN[WD-1:0];
        else                  return v[WD-1:0];
    endfunction

    assign in_ready_o = !rst_i && (state == IDLE) && !clear_i;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     state <= IDLE;
        else if (en_i) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_clear  = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (en_i && clear_i) begin
                    do_clear = 1'b1;
                end else if (en_i && in_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (en_i && step == 3'd4 && sec == SEC_W'(SOS_NUM - 1)) begin
                    last_step = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (en_i && out_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand routing for the shared multiplier; coefficient slots are b0,b1,b2,a1,a2.
    always_comb begin
        cidx   = 3'd0;
        opnd   = x;
        addend = '0;
        sub    = 1'b0;
        case (step)
            3'd0: begin cidx = 3'd0; addend = AW'(s1[chan][sec]) <<< COF_FRAC; end
            3'd1: begin cidx = 3'd1; addend = AW'(s2[chan][sec]) <<< COF_FRAC; end
            3'd2: begin cidx = 3'd3; opnd = y; addend = acc; sub = 1'b1; end
            3'd3: begin cidx = 3'd2; end
            3'd4: begin cidx = 3'd4; opnd = y; addend = acc; sub = 1'b1; end
            default: cidx = 3'd0;
        endcase
        cbase   = (int'(sec) * 5 + int'(cidx)) * int'(COF_WD);
        coef    = $signed(coeff_i[cbase +: COF_WD]);
        prod    = PW'(coef) * PW'(opnd);
        acc_nxt = sub ? (addend - AW'(prod)) : (addend + AW'(prod));
        sat_q   = sat_acc(acc_nxt);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step        <= '0;
            sec         <= '0;
            chan        <= '0;
            x           <= '0;
            y           <= '0;
            acc         <= '0;
            out_valid_o <= 1'b0;
            out_chan_o  <= '0;
            out_data_o  <= '0;
            for (int c = 0; c < int'(CH_NUM); c++) begin
                for (int k = 0; k < int'(SOS_NUM); k++) begin
                    s1[c][k] <= '0;
                    s2[c][k] <= '0;
                end
            end
        end else if (en_i) begin
            if (do_clear) begin
                for (int c = 0; c < int'(CH_NUM); c++) begin
                    for (int k = 0; k < int'(SOS_NUM); k++) begin
                        s1[c][k] <= '0;
                        s2[c][k] <= '0;
                    end
                end
            end
            if (accept) begin
                chan <= in_chan_i;
                x    <= IIR_WD'($signed(in_data_i));
                sec  <= '0;
                step <= '0;
            end
            if (state == CALC) begin
                acc <= acc_nxt;
                case (step)
                    3'd0: y <= sat_q;
                    3'd2: s1[chan][sec] <= sat_q;
                    3'd4: begin
                        s2[chan][sec] <= sat_q;
                        x             <= y;
                    end
                    default: ;
                endcase
                if (step == 3'd4) begin
                    step <= '0;
                    sec  <= last_step ? '0 : sec + 1'b1;
                end else begin
                    step <= step + 3'd1;
                end
                if (last_step) begin
                    out_valid_o <= 1'b1;
                    out_data_o  <= sat_out(y);
                    out_chan_o  <= chan;
                end
            end
            if (state == OUT && out_ready_i) out_valid_o <= 1'b0;
        end
    end

    // Channel numbers at or above CH_NUM have no state slot.
    always @(posedge clk_i) begin
        if (!rst_i && accept) begin
            assert (32'(in_chan_i) < CH_NUM)
            else $error("in_chan_i %0d out of range", in_chan_i);
        end
    end
endmodule

// File: tb/tb_cascade_sos_iir_tdm.sv
// Directed and random bench for cascade_sos_iir_tdm with a difference-equation model.
module tb_cascade_sos_iir_tdm;
    localparam int unsigned WD       = 16;
    localparam int unsigned IIR_WD   = 24;
    localparam int unsigned COF_WD   = 18;
    localparam int unsigned COF_FRAC = 14;
    localparam int unsigned SOS_NUM  = 2;
    localparam int unsigned CH_NUM   = 2;
    localparam int unsigned CH_W     = 1;
    localparam int unsigned CW       = SOS_NUM * 5 * COF_WD;

    logic clk = 1'b0;
    logic rst, en, clear, in_valid, in_ready, out_valid, out_ready, busy;
    logic [CH_W-1:0] in_chan, out_chan;
    logic [WD-1:0]   in_data, out_data;
    logic [CW-1:0]   coeff;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc, last_lat;

    // Reference coefficients per section: index 0..4 = b0, b1, b2, a1, a2.
    longint cb  [SOS_NUM][5];
    longint ms1 [CH_NUM][SOS_NUM];
    longint ms2 [CH_NUM][SOS_NUM];

    cascade_sos_iir_tdm #(
        .WD(WD), .IIR_WD(IIR_WD), .COF_WD(COF_WD), .COF_FRAC(COF_FRAC),
        .SOS_NUM(SOS_NUM), .CH_NUM(CH_NUM)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_chan_i(in_chan),
        .in_data_i(in_data), .coeff_i(coeff), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_chan_o(out_chan), .out_data_o(out_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic longint satn(input longint v, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // y = b0*x + s1; s1' = b1*x - a1*y + s2; s2' = b2*x - a2*y, in Q(COF_FRAC) with floor.
    function automatic longint model_step(input int ch, input longint xin);
        longint xv, yv, q;
        xv = xin;
        q  = 64'sd1 <<< COF_FRAC;
        for (int k = 0; k < int'(SOS_NUM); k++) begin
            yv = satn((ms1[ch][k] * q + cb[k][0] * xv) >>> COF_FRAC, IIR_WD);
            ms1[ch][k] = satn((ms2[ch][k] * q + cb[k][1] * xv - cb[k][3] * yv) >>> COF_FRAC, IIR_WD);
            ms2[ch][k] = satn((cb[k][2] * xv - cb[k][4] * yv) >>> COF_FRAC, IIR_WD);
            xv = yv;
        end
        return satn(xv, WD);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < int'(CH_NUM); c++)
            for (int k = 0; k < int'(SOS_NUM); k++) begin
                ms1[c][k] = 0;
                ms2[c][k] = 0;
            end
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_sec(input int k, input longint b0, input longint b1, input longint b2,
                           input longint a1, input longint a2);
        longint v [5];
        v = '{b0, b1, b2, a1, a2};
        for (int i = 0; i < 5; i++) begin
            cb[k][i] = v[i];
            coeff[(k * 5 + i) * COF_WD +: COF_WD] = COF_WD'(v[i]);
        end
    endtask

    task automatic send(input int ch, input int d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = CH_W'(ch);
        in_data  = WD'(d);
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic signed [31:0] got, output logic [CH_W-1:0] gch);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("recv_timeout", out_valid, 1);
        got      = $signed(out_data);
        gch      = out_chan;
        last_lat = cyc - last_acc;
        @(posedge clk); #1;
    endtask

    task automatic run(input int ch, input int d, output logic signed [31:0] got);
        logic [CH_W-1:0] gch;
        longint e;
        send(ch, d);
        recv(got, gch);
        e = model_step(ch, d);
        check("model_data", got, 32'(e));
        check("model_chan", gch, ch);
    endtask

    task automatic dut_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
    endtask

    task automatic one_pole();
        set_sec(0, 16384, 0, 0, -8192, 0);
        set_sec(1, 16384, 0, 0, 0, 0);
    endtask

    initial begin
        logic signed [31:0] got;
        logic [CH_W-1:0] gch;
        int prev_acc, vcount, hold_d;
        logic stable;
        int seq [4];
        seq = '{1000, 500, 250, 125};

        rst = 1'b1; en = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_chan = '0; in_data = '0; coeff = '0;
        model_clear();
        for (int k = 0; k < int'(SOS_NUM); k++) set_sec(k, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst = 1'b0;

        // Identity cascade: latency counted with the accept cycle as cycle 1
        set_sec(0, 16384, 0, 0, 0, 0);
        set_sec(1, 16384, 0, 0, 0, 0);
        run(0, 1000, got);
        check("ident_data", got, 1000);
        check("ident_latency", last_lat + 1, 5 * SOS_NUM + 1);
        prev_acc = last_acc;
        run(1, -1234, got);
        check("ident_neg", got, -1234);
        check("throughput", last_acc - prev_acc, 5 * SOS_NUM + 2);

        // One-pole impulse response
        dut_clear();
        one_pole();
        for (int i = 0; i < 4; i++) begin
            run(0, (i == 0) ? 1000 : 0, got);
            check("onepole", got, seq[i]);
        end

        // Channel isolation
        dut_clear();
        for (int i = 0; i < 4; i++) begin
            run(0, (i == 0) ? 1000 : 0, got);
            check("iso_ch0", got, seq[i]);
            run(1, 0, got);
            check("iso_ch1", got, 0);
        end

        // Saturation through a gain of 4
        dut_clear();
        set_sec(0, 65536, 0, 0, 0, 0);
        set_sec(1, 16384, 0, 0, 0, 0);
        run(0, 20000, got);
        check("sat_pos", got, 32767);
        run(0, -20000, got);
        check("sat_neg", got, -32768);
        run(0, 0, got);
        check("sat_nowrap", got, 0);

        // Backpressure with a pending input
        dut_clear();
        one_pole();
        out_ready = 1'b0;
        send(0, 1000);
        void'(model_step(0, 1000));
        vcount = 0;
        while (out_valid !== 1'b1 && vcount < 200) begin @(posedge clk); #1; vcount++; end
        hold_d = $signed(out_data);
        check("bp_data", hold_d, 1000);
        @(negedge clk);
        in_valid = 1'b1; in_chan = 1'b1; in_data = '0;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || $signed(out_data) !== hold_d || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        last_acc = cyc;
        check("bp_pending_accept", busy, 1);
        in_valid = 1'b0;
        recv(got, gch);
        check("bp_pending_data", got, 32'(model_step(1, 0)));
        check("bp_pending_chan", gch, 1);

        // Reset mid-CALC aborts the sample
        send(0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 0);
        @(negedge clk) rst = 1'b0;
        model_clear();
        vcount = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid === 1'b1) vcount++; end
        check("midrst_no_output", vcount, 0);
        run(0, 1000, got);
        check("midrst_fresh0", got, 1000);
        run(0, 0, got);
        check("midrst_fresh1", got, 500);

        // clear_i beats a simultaneous in_valid_i
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_chan = '0; in_data = WD'(1000);
        #1;
        check("clr_ready", in_ready, 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        model_clear();
        check("clr_not_accepted", busy, 0);
        run(0, 0, got);
        check("clr_tail_zero", got, 0);
        run(0, 1000, got);
        check("clr_restart0", got, 1000);
        run(0, 0, got);
        check("clr_restart1", got, 500);

        // en_i low freezes the computation
        send(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("en_frozen_busy", busy, 1);
        @(negedge clk) en = 1'b1;
        recv(got, gch);
        check("en_data", got, 32'(model_step(0, 0)));
        check("en_data_const", got, 250);
        check("en_latency", last_lat, 5 * SOS_NUM + 10);

        // Random coefficients, channels and samples
        dut_clear();
        for (int k = 0; k < int'(SOS_NUM); k++)
            set_sec(k, longint'($urandom_range(48000)) - 24000, longint'($urandom_range(48000)) - 24000,
                    longint'($urandom_range(48000)) - 24000, longint'($urandom_range(48000)) - 24000,
                    longint'($urandom_range(48000)) - 24000);
        for (int i = 0; i < 40; i++) begin
            run(int'($urandom_range(CH_NUM - 1)), int'($urandom_range(65535)) - 32768, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
